// File: rtl/systolic_pe_param_if.sv
// -----------------------------------------------------------------------------
// systolic_pe_param_if
// Sample/coefficient/result bundle for one systolic_pe_param stage.
//   master : drives in_valid, in_word, coef_we, coef_addr, coef_data;
//            observes in_ready, out_valid, out_word, frame_done, ovf.
//   slave  : the PE side (opposite directions).
// WORDLENGTH and IDXW must match the parameters of the PE it connects to.
// -----------------------------------------------------------------------------
interface systolic_pe_param_if #(
    parameter int WORDLENGTH = 16,
    parameter int IDXW       = 3
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [WORDLENGTH-1:0] in_word;
    logic                  coef_we;
    logic [IDXW-1:0]       coef_addr;
    logic [WORDLENGTH-1:0] coef_data;
    logic                  out_valid;
    logic [WORDLENGTH-1:0] out_word;
    logic                  frame_done;
    logic                  ovf;

    modport master (
        output in_valid, in_word, coef_we, coef_addr, coef_data,
        input  in_ready, out_valid, out_word, frame_done, ovf
    );

    modport slave (
        input  in_valid, in_word, coef_we, coef_addr, coef_data,
        output in_ready, out_valid, out_word, frame_done, ovf
    );
endinterface

// File: rtl/systolic_pe_param.sv
// -----------------------------------------------------------------------------
// systolic_pe_param
// Systolic processing element: one multiply-accumulate per accepted sample
// against a row of TAPS runtime-loadable coefficients. The multiply is a
// sequential shift-add over magnitudes (WORDLENGTH cycles), sign applied at
// the end, product scaled by >>> FRAC. The partial sum restarts whenever the
// rotating tap index equals START_INDEX.
//
// Ports:
//   clk30x : sample-domain clock
//   reset  : synchronous, active-high
//   pe     : systolic_pe_param_if.slave
//            in_valid/in_ready/in_word     sample handshake
//            coef_we/coef_addr/coef_data   coefficient write port (any state)
//            out_valid                     one-cycle pulse, out_word updated
//            out_word                      partial/complete sum
//            frame_done                    with out_valid on the last tap of a row
//            ovf                           sticky overflow flag
//
// Build option: define SYSTOLIC_PE_SAT_EN to saturate product and sum and
// drive the sticky ovf flag; otherwise results wrap and ovf is tied to 0.
// -----------------------------------------------------------------------------
module systolic_pe_param #(
    parameter int WORDLENGTH  = 16,
    parameter int TAPS        = 8,
    parameter int IDXW        = 3,
    parameter int FRAC        = 14,
    parameter int START_INDEX = 0
) (
    input  logic               clk30x,
    input  logic               reset,
    systolic_pe_param_if.slave pe
);
    localparam int W2  = 2 * WORDLENGTH;
    localparam int CW  = $clog2(WORDLENGTH);
    localparam int MSB = WORDLENGTH - 1;
    localparam logic [IDXW-1:0] START     = IDXW'(START_INDEX);
    localparam logic [IDXW-1:0] LAST_TAP  = IDXW'(TAPS - 1);
    localparam logic [IDXW-1:0] FRAME_END = IDXW'((START_INDEX + TAPS - 1) % TAPS);
    localparam logic [CW-1:0]   LAST_STEP = CW'(WORDLENGTH - 1);

    typedef enum logic [1:0] {IDLE, MULT, ACC, OUT} state_t;

    state_t state, state_next;
    logic   ready, accept, step, acc_en, out_en;

    logic [WORDLENGTH-1:0] coef [TAPS];
    logic [IDXW-1:0]       idx, sel;
    logic [CW-1:0]         cnt;
    logic [W2-1:0]         mcand, prod_acc;
    logic [WORDLENGTH-1:0] mplier;
    logic                  neg;
    logic [WORDLENGTH-1:0] sum_q, out_word_q;
    logic                  frame_q, out_valid_q, frame_done_q;

    logic [WORDLENGTH-1:0] coef_sel, coef_mag, in_mag;
    logic signed [W2-1:0]  prod_full;
    logic [WORDLENGTH-1:0] prod_red, sum;

    // ---------------- FSM ----------------
    always_ff @(posedge clk30x) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        accept     = 1'b0;
        step       = 1'b0;
        acc_en     = 1'b0;
        out_en     = 1'b0;
        case (state)
            IDLE: begin
                ready = !reset;
                if (pe.in_valid && !reset) begin
                    accept     = 1'b1;
                    state_next = MULT;
                end
            end
            MULT: begin
                step = 1'b1;
                if (cnt == LAST_STEP) state_next = ACC;
            end
            ACC: begin
                acc_en     = 1'b1;
                state_next = OUT;
            end
            OUT: begin
                out_en     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- coefficient bank ----------------
    always_ff @(posedge clk30x) begin
        if (reset) begin
            for (int unsigned i = 0; i < TAPS; i++) coef[i] <= '0;
        end else if (pe.coef_we && (int'(pe.coef_addr) < TAPS)) begin
            coef[pe.coef_addr] <= pe.coef_data;
        end
    end

    // Tap idx uses coefficient slot (idx - START_INDEX) mod TAPS.
    always_comb begin
        if (idx >= START) sel = idx - START;
        else              sel = idx + IDXW'(TAPS - START_INDEX);
        coef_sel = coef[sel];
        coef_mag = coef_sel[MSB] ? (~coef_sel + 1'b1) : coef_sel;
        in_mag   = pe.in_word[MSB] ? (~pe.in_word + 1'b1) : pe.in_word;
    end

    // ---------------- product reduction and accumulation ----------------
`ifdef SYSTOLIC_PE_SAT_EN
    logic signed [W2-1:0]   prod_shift;
    logic [WORDLENGTH:0]    sum_ext;
    logic                   clip;
    logic                   ovf_q;

    always_comb begin
        prod_full  = neg ? -$signed(prod_acc) : $signed(prod_acc);
        prod_shift = prod_full >>> FRAC;
        clip       = 1'b0;
        // Fits in WL bits only when all bits above the WL sign bit match it.
        if (prod_shift[W2-1:MSB] != {(W2-MSB){prod_shift[W2-1]}}) begin
            prod_red = prod_shift[W2-1] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
            clip     = 1'b1;
        end else begin
            prod_red = prod_shift[MSB:0];
        end
        if (idx == START) sum_ext = {prod_red[MSB], prod_red};
        else              sum_ext = {prod_red[MSB], prod_red} + {out_word_q[MSB], out_word_q};
        if (sum_ext[WORDLENGTH] != sum_ext[MSB]) begin
            sum  = sum_ext[WORDLENGTH] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
            clip = 1'b1;
        end else begin
            sum = sum_ext[MSB:0];
        end
    end

    always_ff @(posedge clk30x) begin
        if (reset)               ovf_q <= 1'b0;
        else if (acc_en && clip) ovf_q <= 1'b1;
    end

    assign pe.ovf = ovf_q;
`else
    always_comb begin
        prod_full = neg ? -$signed(prod_acc) : $signed(prod_acc);
        prod_red  = WORDLENGTH'(prod_full >>> FRAC);
        sum       = (idx == START) ? prod_red : prod_red + out_word_q;
    end

    assign pe.ovf = 1'b0;
`endif

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk30x) begin
        if (reset) begin
            idx          <= '0;
            cnt          <= '0;
            mcand        <= '0;
            prod_acc     <= '0;
            mplier       <= '0;
            neg          <= 1'b0;
            sum_q        <= '0;
            frame_q      <= 1'b0;
            out_word_q   <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            out_valid_q  <= out_en;
            frame_done_q <= out_en && frame_q;
            if (accept) begin
                cnt      <= '0;
                mcand    <= {{WORDLENGTH{1'b0}}, in_mag};
                mplier   <= coef_mag;
                prod_acc <= '0;
                neg      <= pe.in_word[MSB] ^ coef_sel[MSB];
            end
            if (step) begin
                if (mplier[0]) prod_acc <= prod_acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
            end
            if (acc_en) begin
                sum_q   <= sum;
                frame_q <= (idx == FRAME_END);
                idx     <= (idx == LAST_TAP) ? '0 : idx + 1'b1;
            end
            // Result is staged in sum_q and published one cycle later so that
            // out_valid and out_word change together on the OUT edge.
            if (out_en) out_word_q <= sum_q;
        end
    end

    assign pe.in_ready   = ready;
    assign pe.out_valid  = out_valid_q;
    assign pe.out_word   = out_word_q;
    assign pe.frame_done = frame_done_q;
endmodule

// File: tb/tb_systolic_pe_param.sv
// -----------------------------------------------------------------------------
// tb_systolic_pe_param
// Directed bench for systolic_pe_param (WL=16, FRAC=14, TAPS=8, START_INDEX=0).
// Stimulus pushes hand-computed expectations into a scoreboard queue; an
// independent monitor pops and compares on every out_valid pulse.
// -----------------------------------------------------------------------------
module tb_systolic_pe_param;
    localparam int PERIOD = 10;

    logic clk30x = 1'b0;
    logic reset;

    always #(PERIOD/2) clk30x = ~clk30x;

    systolic_pe_param_if #(.WORDLENGTH(16), .IDXW(3)) pe ();

    systolic_pe_param #(
        .WORDLENGTH(16),
        .TAPS(8),
        .IDXW(3),
        .FRAC(14),
        .START_INDEX(0)
    ) dut (
        .clk30x(clk30x),
        .reset(reset),
        .pe(pe)
    );

    typedef struct {
        logic [15:0] w;
        logic        fd;
        logic        ov;
        time         t;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk30x) begin
        if (pe.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected out_valid: got out_word 0x%0h, expected no output (t=%0t)",
                         pe.out_word, $time);
            end else begin
                e = sb.pop_front();
                check("out_word",   pe.out_word,   e.w);
                check("frame_done", pe.frame_done, e.fd);
                check("ovf",        pe.ovf,        e.ov);
                check("latency",    32'($time - e.t), 18*PERIOD + PERIOD/2);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr_coef(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk30x);
        pe.coef_we   = 1'b1;
        pe.coef_addr = a;
        pe.coef_data = d;
        @(negedge clk30x);
        pe.coef_we   = 1'b0;
    endtask

    task automatic send(input logic [15:0] w, input logic [15:0] ew,
                        input logic efd, input logic eov, input bit expect_out);
        int guard = 0;
        @(negedge clk30x);
        while (pe.in_ready !== 1'b1 && guard < 100) begin
            @(negedge clk30x);
            guard++;
        end
        if (pe.in_ready !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL in_ready wait: got in_ready=%b after 100 cycles, expected 1", pe.in_ready);
            return;
        end
        pe.in_valid = 1'b1;
        pe.in_word  = w;
        if (expect_out) sb.push_back('{w: ew, fd: efd, ov: eov, t: $time + PERIOD/2});
        @(posedge clk30x);
        #1 pe.in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(negedge clk30x);
            guard++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: got %0d outputs still pending, expected 0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk30x);
    endtask

    task automatic do_reset();
        @(negedge clk30x);
        reset = 1'b1;
        @(negedge clk30x);
        check("in_ready during reset", pe.in_ready, 0);
        reset = 1'b0;
        @(negedge clk30x);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        time tprev;
        time tnow;
        int  guard;
        int  low_bad;

        reset        = 1'b1;
        pe.in_valid  = 1'b0;
        pe.in_word   = '0;
        pe.coef_we   = 1'b0;
        pe.coef_addr = '0;
        pe.coef_data = '0;

        // Reset state
        do_reset();
        check("in_ready after reset",   pe.in_ready,   1);
        check("out_valid after reset",  pe.out_valid,  0);
        check("out_word after reset",   pe.out_word,   0);
        check("frame_done after reset", pe.frame_done, 0);
        check("ovf after reset",        pe.ovf,        0);

        // 0x1000 * 1.0
        wr_coef(3'd0, 16'h4000);
        send(16'h1000, 16'h1000, 1'b0, 1'b0, 1'b1);
        drain();

        // Full row of 0.5 * 0.125, then restart
        do_reset();
        for (int i = 0; i < 8; i++) wr_coef(3'(i), 16'h2000);
        for (int k = 1; k <= 9; k++)
            send(16'h0800, (k <= 8) ? 16'(k * 16'h0400) : 16'h0400, (k == 8), 1'b0, 1'b1);
        drain();

        // Negative coefficient and overflow
        do_reset();
        wr_coef(3'd0, 16'hC000);
        send(16'h0100, 16'hFF00, 1'b0, 1'b0, 1'b1);
        drain();
        do_reset();
        wr_coef(3'd0, 16'hC000);
`ifdef SYSTOLIC_PE_SAT_EN
        send(16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b1);
        send(16'h0100, 16'h7FFF, 1'b0, 1'b1, 1'b1);
`else
        send(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1);
        send(16'h0100, 16'h8000, 1'b0, 1'b0, 1'b1);
`endif
        drain();
        do_reset();
        check("ovf cleared by reset", pe.ovf, 0);

        // in_valid held high: accept spacing and in_ready low window
        for (int i = 0; i < 8; i++) wr_coef(3'(i), 16'h2000);
        pe.in_word  = 16'h0800;
        pe.in_valid = 1'b1;
        tprev = 0;
        for (int k = 0; k < 3; k++) begin
            guard = 0;
            while (pe.in_ready !== 1'b1 && guard < 40) begin
                @(negedge clk30x);
                guard++;
            end
            if (pe.in_ready !== 1'b1) begin
                n_cmp++;
                n_fail++;
                $display("FAIL continuous accept wait: got in_ready=%b, expected 1", pe.in_ready);
                break;
            end
            tnow = $time;
            if (k > 0) check("accept spacing", 32'(tnow - tprev), 19*PERIOD);
            tprev = tnow;
            sb.push_back('{w: 16'((k + 1) * 16'h0400), fd: 1'b0, ov: 1'b0, t: tnow + PERIOD/2});
            low_bad = 0;
            for (int j = 1; j <= 18; j++) begin
                @(negedge clk30x);
                if (k == 2 && j == 1) pe.in_valid = 1'b0;
                if (pe.in_ready !== 1'b0) low_bad++;
            end
            check("in_ready low window", low_bad, 0);
        end
        pe.in_valid = 1'b0;
        drain();

        // Reset in the middle of MULT
        do_reset();
        wr_coef(3'd0, 16'h4000);
        send(16'h1000, 16'h0000, 1'b0, 1'b0, 1'b0);
        repeat (6) @(posedge clk30x);
        @(negedge clk30x);
        reset = 1'b1;
        @(negedge clk30x);
        reset = 1'b0;
        check("out_word after mid-MULT reset", pe.out_word, 0);
        repeat (25) @(negedge clk30x);
        check("out_word stays 0 after abort", pe.out_word, 0);
        wr_coef(3'd0, 16'h4000);
        wr_coef(3'd1, 16'h2000);
        send(16'h1000, 16'h1000, 1'b0, 1'b0, 1'b1);
        drain();

        // Coefficient write to the active slot during MULT
        do_reset();
        wr_coef(3'd0, 16'h4000);
        send(16'h1000, 16'h1000, 1'b0, 1'b0, 1'b1);
        send(16'h1000, 16'h1000, 1'b0, 1'b0, 1'b1);
        wr_coef(3'd1, 16'h4000);
        for (int t = 2; t <= 7; t++) send(16'h1000, 16'h1000, (t == 7), 1'b0, 1'b1);
        send(16'h1000, 16'h1000, 1'b0, 1'b0, 1'b1);
        send(16'h1000, 16'h2000, 1'b0, 1'b0, 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation time %0t, expected completion earlier", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/systolic_pe_param.md
# systolic_pe_param

Parametrised systolic processing element for the Chebyshev interpolation array: one multiply-accumulate per input word against a row of runtime-loadable coefficients, with a generic tap count and a valid/ready handshake. Each accepted sample is multiplied on a sequential shift-add multiplier by the coefficient selected by the rotating tap index. The product is added to the running partial sum, which restarts at this PE's start position. PEs chain in the array; `out_word` feeds the next stage.

## Interface
- `WORDLENGTH`, 16, data/coefficient width, two's complement.
- `TAPS`, 8, coefficients per row (2..2**IDXW).
- `IDXW`, 3, tap-index/address width.
- `FRAC`, 14, coefficient fractional bits (Q(WL-FRAC).FRAC).
- `START_INDEX`, 0, tap index at which the partial sum restarts (0..TAPS-1).

Ports:
- `clk30x`  in  1  sample-domain clock.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  `in_word` valid.
- `in_ready`  out  1  PE can accept a sample.
- `in_word`  in  WORDLENGTH  sampled signal value.
- `coef_we`  in  1  coefficient write strobe.
- `coef_addr`  in  IDXW  coefficient slot; writes with `coef_addr` >= TAPS are ignored.
- `coef_data`  in  WORDLENGTH  coefficient value.
- `out_valid`  out  1  one-cycle pulse, `out_word` updated.
- `out_word`  out  WORDLENGTH  partial/complete sum.
- `frame_done`  out  1  coincident with `out_valid` on the last tap of a row.
- `ovf`  out  1  sticky overflow flag.

## Operation
- FSM states:
  - IDLE: `in_ready`=1. `in_valid` sampled high moves to MULT, latching `in_word` and coefficient C[(idx-START_INDEX) mod TAPS].
  - MULT: WORDLENGTH cycles of signed shift-add (magnitudes multiplied, sign applied at end), then ACC.
  - ACC: 1 cycle, then OUT.
  - OUT: 1 cycle, `out_valid`=1, then IDLE.
- Product: 2*WL-bit signed, arithmetic shift right by FRAC (truncate toward −inf), reduced to WL bits per Configuration.
- ACC: if idx==START_INDEX, sum = product; else sum = product + previous `out_word`, reduced the same way. `out_word` ← sum; idx ← (idx==TAPS-1) ? 0 : idx+1.
- `frame_done` = 1 in OUT when the consumed idx == (START_INDEX+TAPS-1) mod TAPS.
- Coefficient bank: TAPS×WL registers. Writes are accepted in any state. The multiplier uses the value latched at accept; a write to the active slot affects the next use only.
- `reset`: from any state, including mid-MULT, returns to IDLE and discards the in-flight product. idx, `out_word`, `ovf`, `out_valid`, `frame_done` and all coefficients ← 0. `in_ready` is 0 during the reset cycle and 1 from the first cycle after it.

## Timing
- Accept on edge k (IDLE, `in_valid`=1). MULT covers k+1..k+WL, ACC is k+WL+1, and `out_valid`/`out_word` are visible after edge k+WL+2.
- Latency: WORDLENGTH+2 cycles. Throughput: one sample per WORDLENGTH+3 cycles (19 at WL=16).
- `in_ready` is low from the accept edge until OUT returns to IDLE. `in_valid` held high across that window is not consumed again.
- `out_word` holds its value between `out_valid` pulses.

## Configuration
- `SYSTOLIC_PE_SAT_EN` defined: product and sum saturate to [−2^(WL−1), 2^(WL−1)−1]. Any clipping sets `ovf`, which stays set until `reset`.
- Not defined: reduction keeps the low WL bits (modular wrap) and `ovf` is tied to 0.

## Test plan
All cases use WL=16, FRAC=14, TAPS=8, START_INDEX=0.
- Reset, C[0]=0x4000, input 0x1000 → `out_valid` 18 cycles after accept, `out_word`=0x1000, `frame_done`=0.
- C[0..7]=0x2000, eight inputs 0x0800 → `out_word` = 0x0400, 0x0800, … 0x2000; `frame_done` only on the 8th; the 9th sample restarts at 0x0400.
- C[0]=0xC000 (−1.0), input 0x0100 → 0xFF00. Input 0x8000 × 0xC000 → 0x7FFF with `ovf`=1 (SAT_EN), or 0x8000 with `ovf`=0 (no SAT_EN).
- `in_valid` held high continuously → accepts spaced exactly 19 cycles; `in_ready` low for 18 cycles after each accept.
- `reset` asserted at cycle 7 of MULT → no `out_valid`, `out_word`=0, next sample treated as tap 0.
- Write C[1]=0x4000 during the tap-1 MULT (old value 0) → current result uses 0, next row's tap 1 uses 0x4000.
